// File: rtl/a2_2_decoder_seq.sv
// Handshaked 4-to-16 binary-to-one-hot decoder: input FIFO, registered one-hot
// output stage, and a running decoded-bit mask plus saturating handshake count.
module a2_2_decoder_seq #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 4,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y,
  input  logic              acc_mode,
  input  logic              clr,
  output logic [OUT_W-1:0]  mask,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    EMPTY_OUT,
    HOLD
  } out_state_e;

  logic [CODE_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              push;
  logic              load;
  logic              handshake;
  out_state_e        state;
  out_state_e        state_next;

  function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] word;
    for (int i = 0; i < OUT_W; i++) begin
      word[i] = (code == CODE_W'(i));
    end
    return word;
  endfunction

  // Flags come from registered occupancy only, so in_ready never sees out_ready.
  assign empty     = (occ == '0);
  assign full      = (occ == OCC_FULL);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign load      = (!out_valid || out_ready) && !empty;
  assign handshake = out_valid && out_ready;

  // NOTE: the storage array has no reset; resetting the pointers and occupancy
  // already makes stale entries unreachable, and this keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_code;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY_OUT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY_OUT: if (load) state_next = HOLD;
      HOLD:      if (out_ready && empty) state_next = EMPTY_OUT;
      default:   state_next = EMPTY_OUT;
    endcase
  end

  always_comb begin
    out_valid = (state == HOLD);
  end

  // y keeps its last word after the stage empties; only out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (load) begin
      y <= decode(fifo_mem[rd_ptr]);
    end
  end

  // clr wins over a same-cycle handshake, dropping that word's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask  <= '0;
      count <= '0;
    end else if (clr) begin
      mask  <= '0;
      count <= '0;
    end else if (handshake) begin
      mask  <= acc_mode ? (mask | y) : y;
      if (count != CNT_MAX) count <= count + 1'b1;
    end
  end

endmodule

// File: doc/a2_2_decoder_seq.md
# a2_2_decoder_seq

Buffered, handshaked 4-to-16 binary-to-one-hot decoder. It is the inverse of the class-assignment 16-to-4 encoder. Producer-side codes enter through a valid/ready port into a small FIFO. Each code is decoded into a registered one-hot word on a valid/ready output port, and the block keeps a running decoded-bit mask and a handshake count for the bench to check.

## Interface
- DEPTH, 4, FIFO entries; power of 2, at least 2
- CODE_W, 4, input code width
- OUT_W, 16, output width; fixed at 2**CODE_W
- CNT_W, 8, width of the decoded-word counter
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  producer presents in_code
- in_code  input  CODE_W  binary code to decode
- in_ready  output  1  FIFO can accept; equals !full
- out_valid  output  1  y holds a decoded word
- out_ready  input  1  consumer accepts y
- y  output  OUT_W  registered one-hot decode, y[in_code] = 1
- acc_mode  input  1  1: mask ORs decoded words; 0: mask is replaced by each word
- clr  input  1  synchronous clear of mask and count
- mask  output  OUT_W  accumulated or last decoded word
- count  output  CNT_W  number of output handshakes, saturating
- empty  output  1  FIFO holds 0 entries
- full  output  1  FIFO holds DEPTH entries

## Operation
- Push: when in_valid && in_ready at an edge, in_code is written at wr_ptr, wr_ptr increments mod DEPTH, and occupancy increments.
- Pushes are refused while full, even if a pop happens in the same cycle. in_ready is derived combinationally from registered occupancy only.
- Output register behaviour:
  - state EMPTY_OUT: out_valid=0.
  - state HOLD: out_valid=1.
  - Load condition: (!out_valid || out_ready) && !empty.
  - On load: y <= 1 << fifo[rd_ptr], rd_ptr increments, occupancy decrements, and the state becomes HOLD.
  - EMPTY_OUT -> HOLD on load.
  - HOLD -> HOLD when out_ready && !empty; a back-to-back reload is required, with no bubble.
  - HOLD -> EMPTY_OUT when out_ready && empty; y retains its value, but out_valid=0.
  - HOLD with !out_ready: y, out_valid and rd_ptr stay frozen.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged, and both pointers advance.
- Output handshake (out_valid && out_ready):
  - count <= count+1, saturating at 2**CNT_W-1.
  - mask <= acc_mode ? (mask | y) : y.
- clr has priority over a handshake in the same cycle: mask <= 0 and count <= 0, and that handshake's update is dropped. The FIFO and output stage are unaffected.
- Width rules:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy is log2(DEPTH)+1 bits.
  - y is always exactly one-hot or all zero.
- Reset, asynchronous, effective immediately, mid-operation included:
  - FIFO contents discarded; pointers and occupancy 0.
  - y=0, out_valid=0, mask=0, count=0.
  - empty=1, full=0, in_ready=1.

## Timing
- Push at edge N into an empty FIFO with an idle output stage: empty deasserts after N, and the load happens at N+1. out_valid and y are therefore visible after edge N+1, a latency of 2 edges.
- Steady state with out_ready=1 and in_valid=1: throughput is 1 word per cycle.
- mask and count update at the same edge as the handshake and are visible the following cycle.
- full asserts after the edge at which occupancy reaches DEPTH. in_ready drops in that same cycle.
- No combinational path from out_ready to in_ready.

## Test plan
- Reset check: assert rst asynchronously between edges -> all outputs zero immediately; in_ready=1, empty=1.
- Single code: push in_code=4'hA with out_ready=1 -> y=16'h0400 and out_valid=1 two edges after the push; count=1; mask=16'h0400.
- Streaming order: push codes 0,1,...,15 back-to-back with out_ready=1 -> y sequence 16'h0001...16'h8000 at 1 word/cycle; count=16. With acc_mode=1, mask=16'hFFFF. With acc_mode=0, mask=16'h8000.
- Backpressure and full:
  - Hold out_ready=0 and push 5 codes (3,7,7,2,9) -> y=16'h0008 holds; full=1 after 4 FIFO entries plus the held word; the 6th push is refused.
  - Then release out_ready -> outputs in order 0x0008, 0x0080, 0x0080, 0x0004, 0x0200.
- clr collision: assert clr in the same cycle as a handshake of y=16'h0020 -> mask=0 and count=0 the next cycle; the word is dropped from both.
- Saturation and wrap: perform 300 handshakes with random codes ($random) -> count holds at 255. Pointers wrap repeatedly with no reordering; the bench checks each y against a scoreboard queue.
